// File: rtl/rgb_pwm_pkg.sv
// Shared widths and types for the RGB PWM driver.
package rgb_pwm_pkg;
    localparam int DUTY_W    = 4;
    localparam int PWM_STEPS = 15;

    typedef logic [DUTY_W-1:0] duty_t;
endpackage

// File: rtl/pwm_channel.sv
// One LED channel: a double-buffered duty register, a compare against the shared step count,
// and a registered pin drive. Pin polarity and the forced-OFF level come from ACTIVE_LOW.
module pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  enable,
    input  logic  load,
    input  duty_t sample,
    input  duty_t count,
    output logic  led
);
    localparam logic OFF = ACTIVE_LOW;

    duty_t duty;
    duty_t dsel;

    // The load edge compares against the fresh sample so the frame cycle already shows the new duty.
    assign dsel = load ? sample : duty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            duty <= '0;
        end else if (load) begin
            duty <= sample;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led <= OFF;
        end else if (enable && (count < dsel)) begin
            led <= ~OFF;
        end else begin
            led <= OFF;
        end
    end
endmodule

// File: rtl/rgb_pwm_driver.sv
// Turns three 4-bit intensities into PWM pin drives with 15 steps of PRESCALE clocks per period.
// Duties are sampled only at period start; enable low clears the counters and forces the pins OFF.
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int PRESCALE   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  enable,
    input  duty_t r_in,
    input  duty_t g_in,
    input  duty_t b_in,
    output logic  led_r,
    output logic  led_g,
    output logic  led_b,
    output logic  frame
);
    localparam int    PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam duty_t PWM_LAST = DUTY_W'(PWM_STEPS - 1);

    logic [PRE_W-1:0] pre_cnt;
    duty_t            pwm_cnt;
    logic             step;
    logic             load;

    assign step = (pre_cnt == PRE_LAST);
    assign load = enable && (pre_cnt == '0) && (pwm_cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (!enable || step) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else if (!enable) begin
            pwm_cnt <= '0;
        end else if (step) begin
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + DUTY_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame <= 1'b0;
        end else begin
            frame <= load;
        end
    end

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_red (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .load   (load),
        .sample (r_in),
        .count  (pwm_cnt),
        .led    (led_r)
    );

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_green (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .load   (load),
        .sample (g_in),
        .count  (pwm_cnt),
        .led    (led_g)
    );

    pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_blue (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .load   (load),
        .sample (b_in),
        .count  (pwm_cnt),
        .led    (led_b)
    );
endmodule
